// File: rtl/or_8way_event_capture.sv
// Sticky 8-line event capture with registered "any event" flag, first-line index and
// saturating active-cycle counter. Define OR8_EDGE_DETECT_EN to capture rising edges only.
module or_8way_event_capture #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in,
  input  logic               arm,
  input  logic               clear,
  output logic               out,
  output logic [7:0]         pending,
  output logic [2:0]         first_idx,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2
  } state_t;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [7:0]         pending_q, pending_d;
  logic [2:0]         first_idx_q, first_idx_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               out_q, out_d;
  logic [7:0]         cap;

`ifdef OR8_EDGE_DETECT_EN
  // Previous-cycle copy of the lines; runs in every state so edges are never stale.
  logic [7:0] in_q;

  always_ff @(posedge clk) begin
    if (reset) in_q <= 8'h00;
    else       in_q <= in;
  end

  assign cap = in & ~in_q;
`else
  assign cap = in;
`endif

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    first_idx_d = first_idx_q;
    count_d     = count_q;
    out_d       = |pending_q;
    if (clear) begin
      state_d     = ST_IDLE;
      pending_d   = 8'h00;
      first_idx_d = 3'd0;
      count_d     = '0;
      out_d       = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (cap != 8'h00) begin
            state_d     = ST_TRIGGERED;
            pending_d   = cap;
            first_idx_d = lowest_set(cap);
            count_d     = COUNT_W'(1);
          end
        end
        ST_TRIGGERED: begin
          pending_d = pending_q | cap;
          if (cap != 8'h00 && count_q != COUNT_MAX) count_d = count_q + COUNT_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pending_q   <= 8'h00;
      first_idx_q <= 3'd0;
      count_q     <= '0;
      out_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      first_idx_q <= first_idx_d;
      count_q     <= count_d;
      out_q       <= out_d;
    end
  end

  assign out       = out_q;
  assign pending   = pending_q;
  assign first_idx = first_idx_q;
  assign count     = count_q;
  assign busy      = (state_q == ST_ARMED) || (state_q == ST_TRIGGERED);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_or_8way_event_capture.sv
// Directed bench for or_8way_event_capture: vector table plus saturation and edge-mode
// sequences; a second instance with COUNT_W=3 covers counter saturation.
module tb_or_8way_event_capture;

  logic       clk;
  logic       reset;
  logic [7:0] in;
  logic       arm;
  logic       clear;

  logic       out, out_s;
  logic [7:0] pending, pending_s;
  logic [2:0] first_idx, first_idx_s;
  logic [7:0] count;
  logic [2:0] count_s;
  logic       busy, busy_s;
  logic [1:0] dbg_state, dbg_state_s;

  int checks = 0;
  int errors = 0;

  or_8way_event_capture #(.COUNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .in(in), .arm(arm), .clear(clear),
    .out(out), .pending(pending), .first_idx(first_idx), .count(count),
    .busy(busy), .dbg_state(dbg_state)
  );

  or_8way_event_capture #(.COUNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .in(in), .arm(arm), .clear(clear),
    .out(out_s), .pending(pending_s), .first_idx(first_idx_s), .count(count_s),
    .busy(busy_s), .dbg_state(dbg_state_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       reset;
    logic       arm;
    logic       clear;
    logic [7:0] in;
    logic [7:0] exp_pending;
    logic       exp_out;
    logic [2:0] exp_first;
    logic [7:0] exp_count;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic c, input logic [7:0] v);
    reset = r; arm = a; clear = c; in = v;
  endtask

  // Advance one active edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic r, input logic a, input logic c,
                         input logic [7:0] v, input logic [7:0] p, input logic o,
                         input logic [2:0] f, input logic [7:0] n, input logic b);
    vecs[i] = '{r, a, c, v, p, o, f, n, b};
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 8'hFF);

    // Reset with lines high, level build-up, arm+clear collision, reset mid-capture.
    set_vec( 0, 1, 0, 0, 8'hFF, 8'h00, 0, 3'd0, 8'd0, 0);
    set_vec( 1, 1, 0, 0, 8'hFF, 8'h00, 0, 3'd0, 8'd0, 0);
    set_vec( 2, 0, 1, 0, 8'h00, 8'h00, 0, 3'd0, 8'd0, 1);
    set_vec( 3, 0, 0, 0, 8'h00, 8'h00, 0, 3'd0, 8'd0, 1);
    set_vec( 4, 0, 0, 0, 8'h00, 8'h00, 0, 3'd0, 8'd0, 1);
    set_vec( 5, 0, 0, 0, 8'h10, 8'h10, 0, 3'd4, 8'd1, 1);
    set_vec( 6, 0, 0, 0, 8'h26, 8'h36, 1, 3'd4, 8'd2, 1);
    set_vec( 7, 0, 0, 0, 8'h00, 8'h36, 1, 3'd4, 8'd2, 1);
    set_vec( 8, 0, 1, 0, 8'h00, 8'h36, 1, 3'd4, 8'd2, 1);
    set_vec( 9, 0, 1, 1, 8'h00, 8'h00, 0, 3'd0, 8'd0, 0);
    set_vec(10, 0, 0, 0, 8'hFF, 8'h00, 0, 3'd0, 8'd0, 0);
    set_vec(11, 0, 0, 0, 8'hFF, 8'h00, 0, 3'd0, 8'd0, 0);
    set_vec(12, 0, 1, 0, 8'h00, 8'h00, 0, 3'd0, 8'd0, 1);
    set_vec(13, 0, 0, 0, 8'h0F, 8'h0F, 0, 3'd0, 8'd1, 1);
    set_vec(14, 0, 0, 0, 8'h00, 8'h0F, 1, 3'd0, 8'd1, 1);
    set_vec(15, 1, 0, 0, 8'h0F, 8'h00, 0, 3'd0, 8'd0, 0);
    set_vec(16, 0, 1, 0, 8'h00, 8'h00, 0, 3'd0, 8'd0, 1);
    set_vec(17, 0, 0, 0, 8'h08, 8'h08, 0, 3'd3, 8'd1, 1);
    set_vec(18, 0, 0, 0, 8'h00, 8'h08, 1, 3'd3, 8'd1, 1);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].reset, vecs[i].arm, vecs[i].clear, vecs[i].in);
      step();
      check($sformatf("v%0d pending", i), 32'(pending), 32'(vecs[i].exp_pending));
      check($sformatf("v%0d out", i), 32'(out), 32'(vecs[i].exp_out));
      check($sformatf("v%0d first_idx", i), 32'(first_idx), 32'(vecs[i].exp_first));
      check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("v%0d sat_count", i), 32'(count_s), 32'(vecs[i].exp_count[2:0]));
      check($sformatf("v%0d sat_pending", i), 32'(pending_s), 32'(vecs[i].exp_pending));
    end

    // Counter saturation: line 0 held for 10 cycles.
    drive(0, 0, 1, 8'h00); step();
    check("sat clear busy", 32'(busy), 32'd0);
    drive(0, 1, 0, 8'h00); step();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 8'h01); step();
`ifdef OR8_EDGE_DETECT_EN
      check($sformatf("sat c%0d count8", i), 32'(count), 32'd1);
      check($sformatf("sat c%0d count3", i), 32'(count_s), 32'd1);
`else
      check($sformatf("sat c%0d count8", i), 32'(count), 32'(i + 1));
      check($sformatf("sat c%0d count3", i), 32'(count_s), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
`endif
    end
    check("sat first_idx", 32'(first_idx_s), 32'd0);
    check("sat pending", 32'(pending_s), 32'h01);

`ifdef OR8_EDGE_DETECT_EN
    // Held line counts once; a fresh rising edge on another line counts again.
    drive(0, 0, 1, 8'h00); step();
    drive(0, 1, 0, 8'h00); step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 8'h80); step();
      check($sformatf("edge h%0d count", i), 32'(count), 32'd1);
    end
    check("edge pending", 32'(pending), 32'h80);
    check("edge first_idx", 32'(first_idx), 32'd7);
    drive(0, 0, 0, 8'h81); step();
    check("edge second count", 32'(count), 32'd2);
    check("edge second pending", 32'(pending), 32'h81);
    check("edge second first_idx", 32'(first_idx), 32'd7);
`endif

    // Clear zeroes out in the same edge even while pending is set.
    drive(0, 0, 1, 8'h00); step();
    check("final clear out", 32'(out), 32'd0);
    check("final clear pending", 32'(pending), 32'h00);
    check("final clear count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
